// File: rtl/mem_dump_serializer_pkg.sv
// Shared constants and types for the memory readback path.
// The UART load path uses the same memory hold window and byte lane order.
package mem_dump_serializer_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int ADDR_WIDTH          = 32;
    localparam int BYTE_WIDTH          = 8;
    localparam int BYTES_PER_WORD      = 4;
    localparam int BYTE_CNT_WIDTH      = $clog2(BYTES_PER_WORD);
    localparam int WORD_STRIDE         = BYTES_PER_WORD;
    localparam int DEFAULT_MEM_LATENCY = 16;
    localparam int LAT_CNT_WIDTH       = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } dump_state_e;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_dump_serializer_tx_byte_shifter.sv
// Holds one fetched word and presents it to the UART TX port one byte
// at a time, least-significant byte first, with valid/ready handshaking.
module tx_byte_shifter
    import mem_dump_serializer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_tx_ready,
    output logic [BYTE_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_last_xfer
);

    localparam logic [BYTE_CNT_WIDTH-1:0] LAST_BUT_ONE = BYTE_CNT_WIDTH'(BYTES_PER_WORD - 2);

    logic [DATA_WIDTH-1:0]     r_shift;
    logic [BYTE_CNT_WIDTH-1:0] r_byte_cnt;
    logic                      r_last;
    logic                      r_valid;
    logic                      w_xfer;

    assign w_xfer      = r_valid & i_tx_ready;
    assign o_last_xfer = w_xfer & r_last;
    assign o_tx_data   = r_shift[BYTE_WIDTH-1:0];
    assign o_tx_valid  = r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_last     <= 1'b0;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_shift    <= i_load_data;
            r_byte_cnt <= '0;
            r_last     <= 1'b0;
            r_valid    <= 1'b1;
        end else if (w_xfer) begin
            r_shift    <= {{BYTE_WIDTH{1'b0}}, r_shift[DATA_WIDTH-1:BYTE_WIDTH]};
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_last     <= (r_byte_cnt == LAST_BUT_ONE);
            if (r_last) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_dump_serializer.sv
// Reads a run of words from memory and streams them to the UART transmitter
// as bytes, LSB first, so a loaded image reads back byte-identically.
module mem_dump_serializer
    import mem_dump_serializer_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Start,
    input  logic [ADDR_WIDTH-1:0]  BaseAddr,
    input  logic [COUNT_WIDTH-1:0] WordCount,
    output logic                   Busy,
    output logic                   Done,
    output logic [ADDR_WIDTH-1:0]  MemAddr,
    output logic                   MemRead,
    input  logic [DATA_WIDTH-1:0]  MemData,
    output logic [BYTE_WIDTH-1:0]  TxData,
    output logic                   TxValid,
    input  logic                   TxReady
);

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LAST  = LAT_CNT_WIDTH'(MEM_LATENCY - 1);
    localparam logic [COUNT_WIDTH-1:0]   ONE_WORD  = COUNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_STEP = ADDR_WIDTH'(WORD_STRIDE);

    dump_state_e             r_state;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic                    r_mem_read;
    logic                    r_busy;
    logic                    r_done;
    logic [COUNT_WIDTH-1:0]  r_remaining;
    logic [LAT_CNT_WIDTH-1:0] r_lat_cnt;

    logic                    w_load;
    logic                    w_last_xfer;

    // Load on the edge that ends the final FETCH cycle, while MemData is valid.
    assign w_load = (r_state == S_FETCH) && (r_lat_cnt == LAT_LAST);

    tx_byte_shifter u_tx_byte_shifter (
        .clk         (clk),
        .rst_n       (reset),
        .i_load      (w_load),
        .i_load_data (MemData),
        .i_tx_ready  (TxReady),
        .o_tx_data   (TxData),
        .o_tx_valid  (TxValid),
        .o_last_xfer (w_last_xfer)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_mem_read  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_lat_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_busy <= 1'b1;
                        if (WordCount != '0) begin
                            r_mem_addr  <= word_align(BaseAddr);
                            r_remaining <= WordCount;
                            r_lat_cnt   <= '0;
                            r_mem_read  <= 1'b1;
                            r_state     <= S_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_FETCH: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_lat_cnt  <= '0;
                        r_mem_read <= 1'b0;
                        r_state    <= S_SEND;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end

                S_SEND: begin
                    if (w_last_xfer) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == ONE_WORD) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_mem_addr <= r_mem_addr + ADDR_STEP;
                            r_mem_read <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign MemAddr = r_mem_addr;
    assign MemRead = r_mem_read;

endmodule

// File: tb/tb_mem_dump_serializer.sv
// Directed bench for mem_dump_serializer: table of dump commands plus a
// hand-written reset-mid-dump sequence.
module tb_mem_dump_serializer;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [31:0] BaseAddr;
    logic [15:0] WordCount;
    logic        Busy;
    logic        Done;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic [31:0] MemData;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;

    int n_checks = 0;
    int n_errors = 0;

    mem_dump_serializer #(
        .MEM_LATENCY (16),
        .COUNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .Start     (Start),
        .BaseAddr  (BaseAddr),
        .WordCount (WordCount),
        .Busy      (Busy),
        .Done      (Done),
        .MemAddr   (MemAddr),
        .MemRead   (MemRead),
        .MemData   (MemData),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .TxReady   (TxReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: return 32'hDDCC_BBAA;
            32'h0000_0200: return 32'h0D0C_0B0A;
            32'hFFFF_FFFC: return 32'h4433_2211;
            32'h0000_0000: return 32'h8877_6655;
            default:       return 32'hDEAD_0000 ^ addr;
        endcase
    endfunction

    assign MemData = mem_model(MemAddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]      base;
        logic [15:0]      cnt;
        logic [3:0]       rdy;        // TxReady by cycle index mod 4
        int               extra_cyc;  // cycle of a second Start, -1 for none
        logic [31:0]      extra_base;
        int               nwords;
        logic [1:0][31:0] words;
        logic [1:0][31:0] addrs;
        int               done_cyc;
    } vec_t;

    localparam int NVEC   = 6;
    localparam int BUDGET = 200;

    vec_t vecs [NVEC];

    logic [7:0]  q_bytes[$];
    logic [31:0] q_addrs[$];
    int          n_rd;
    int          n_done;
    int          done_cyc;
    int          idle_cyc;
    int          n_overlap;
    int          n_stall_err;
    logic        timed_out;

    task automatic run_cmd(input logic [31:0] base, input logic [15:0] cnt, input logic [3:0] rdy,
                           input int extra_cyc, input logic [31:0] extra_base);
        logic       prev_rd;
        logic       prev_stall;
        logic [7:0] prev_data;
        q_bytes.delete();
        q_addrs.delete();
        n_rd = 0; n_done = 0; done_cyc = -1; idle_cyc = -1;
        n_overlap = 0; n_stall_err = 0; timed_out = 1'b1;
        prev_rd = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
        @(negedge clk);
        BaseAddr = base; WordCount = cnt; Start = 1'b1; TxReady = 1'b0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            Start = 1'b0;
            if (cyc == extra_cyc) begin
                Start = 1'b1; BaseAddr = extra_base; WordCount = 16'd3;
            end
            TxReady = rdy[cyc % 4];
            if (MemRead) begin
                n_rd++;
                if (!prev_rd) q_addrs.push_back(MemAddr);
            end
            if (MemRead && TxValid) n_overlap++;
            if (prev_stall && (!TxValid || TxData != prev_data)) n_stall_err++;
            if (TxValid && TxReady) q_bytes.push_back(TxData);
            prev_stall = TxValid && !TxReady;
            prev_data  = TxData;
            prev_rd    = MemRead;
            if (Done) begin
                n_done++;
                done_cyc = cyc;
            end else if (n_done > 0 && !Busy) begin
                idle_cyc  = cyc;
                timed_out = 1'b0;
                break;
            end
        end
        Start = 1'b0; TxReady = 1'b0;
    endtask

    task automatic check_run(input string tag, input vec_t v);
        logic [31:0] w;
        logic [7:0]  got;
        check({tag, "_timeout"}, 32'(timed_out), 32'd0);
        check({tag, "_nbytes"}, q_bytes.size(), 32'(v.nwords * 4));
        for (int i = 0; i < v.nwords * 4; i++) begin
            w   = v.words[i / 4];
            got = (i < q_bytes.size()) ? q_bytes[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), {24'h0, got}, {24'h0, w[8 * (i % 4) +: 8]});
        end
        check({tag, "_nfetch"}, q_addrs.size(), 32'(v.nwords));
        for (int i = 0; i < v.nwords; i++) begin
            check($sformatf("%s_addr%0d", tag, i),
                  (i < q_addrs.size()) ? q_addrs[i] : 32'hxxxx_xxxx, v.addrs[i]);
        end
        check({tag, "_memread_cycles"}, n_rd, 32'(v.nwords * 16));
        check({tag, "_done_pulses"}, n_done, 32'd1);
        check({tag, "_done_cyc"}, done_cyc, v.done_cyc);
        check({tag, "_idle_cyc"}, idle_cyc, v.done_cyc + 1);
        check({tag, "_fetch_send_overlap"}, n_overlap, 32'd0);
        check({tag, "_stall_stability"}, n_stall_err, 32'd0);
    endtask

    initial begin
        logic done_seen;

        // single word, zero wait
        vecs[0] = '{base: 32'h100, cnt: 16'd1, rdy: 4'b1111, extra_cyc: -1, extra_base: 32'h0,
                    nwords: 1, words: {32'h0, 32'hDDCC_BBAA}, addrs: {32'h0, 32'h100}, done_cyc: 20};
        // backpressure 1,0,0,1
        vecs[1] = '{base: 32'h100, cnt: 16'd1, rdy: 4'b1001, extra_cyc: -1, extra_base: 32'h0,
                    nwords: 1, words: {32'h0, 32'hDDCC_BBAA}, addrs: {32'h0, 32'h100}, done_cyc: 24};
        // two words across the address wrap
        vecs[2] = '{base: 32'hFFFF_FFFE, cnt: 16'd2, rdy: 4'b1111, extra_cyc: -1, extra_base: 32'h0,
                    nwords: 2, words: {32'h8877_6655, 32'h4433_2211},
                    addrs: {32'h0000_0000, 32'hFFFF_FFFC}, done_cyc: 40};
        // zero count
        vecs[3] = '{base: 32'h100, cnt: 16'd0, rdy: 4'b1111, extra_cyc: -1, extra_base: 32'h0,
                    nwords: 0, words: '0, addrs: '0, done_cyc: 0};
        // second Start during SEND is ignored
        vecs[4] = '{base: 32'h100, cnt: 16'd1, rdy: 4'b1111, extra_cyc: 17, extra_base: 32'h200,
                    nwords: 1, words: {32'h0, 32'hDDCC_BBAA}, addrs: {32'h0, 32'h100}, done_cyc: 20};
        // unaligned base, alternating ready
        vecs[5] = '{base: 32'h203, cnt: 16'd1, rdy: 4'b0101, extra_cyc: -1, extra_base: 32'h0,
                    nwords: 1, words: {32'h0, 32'h0D0C_0B0A}, addrs: {32'h0, 32'h200}, done_cyc: 23};

        rst_n = 1'b0; Start = 1'b0; BaseAddr = '0; WordCount = '0; TxReady = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_memread", 32'(MemRead), 32'd0);
        check("reset_memaddr", MemAddr, 32'd0);
        check("reset_txvalid", 32'(TxValid), 32'd0);
        check("reset_txdata", 32'(TxData), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < NVEC; v++) begin
            run_cmd(vecs[v].base, vecs[v].cnt, vecs[v].rdy, vecs[v].extra_cyc, vecs[v].extra_base);
            check_run($sformatf("vec%0d", v), vecs[v]);
            repeat (2) @(negedge clk);
        end

        // Reset while the second byte of the first word is on the bus.
        @(negedge clk);
        BaseAddr = 32'h100; WordCount = 16'd1; Start = 1'b1; TxReady = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (17) @(negedge clk);
        check("rst_pre_valid", 32'(TxValid), 32'd1);
        check("rst_pre_data", 32'(TxData), 32'hBB);
        #1 rst_n = 1'b0;
        #1;
        check("rst_txvalid", 32'(TxValid), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_txdata", 32'(TxData), 32'd0);
        check("rst_memaddr", MemAddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        TxReady = 1'b0;
        done_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (Done || Busy) done_seen = 1'b1;
        end
        check("rst_no_done_after_abort", 32'(done_seen), 32'd0);

        run_cmd(32'hFFFF_FFFC, 16'd1, 4'b1111, -1, 32'h0);
        check_run("post_reset", '{base: 32'hFFFF_FFFC, cnt: 16'd1, rdy: 4'b1111, extra_cyc: -1,
                                  extra_base: 32'h0, nwords: 1, words: {32'h0, 32'h4433_2211},
                                  addrs: {32'h0, 32'hFFFF_FFFC}, done_cyc: 20});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_dump_serializer.md
# mem_dump_serializer

Readback counterpart of the UART load path: fetches a run of 32-bit words from instruction/data memory and emits them as a byte stream to the UART transmitter. Each word is sent as four bytes, least-significant first, the same byte order the load path assembles. A fresh program image therefore round-trips byte-identically. Sits between the memory read port and the UART TX byte interface; started by a one-cycle command from the debug/IO controller.

## Interface
- MEM_LATENCY, 16: cycles the address and MemRead are held before MemData is sampled. Must match the write-side memory hold window. Legal range 1..255.
- COUNT_WIDTH, 16: width of the word-count input.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low. Clears all state immediately.
- Start  in  1  one-cycle command. Sampled only in IDLE.
- BaseAddr  in  32  first word address. Bits [1:0] are ignored and forced to 0.
- WordCount  in  COUNT_WIDTH  number of words to dump. Latched with Start.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when a dump completes.
- MemAddr  out  32  word-aligned read address.
- MemRead  out  1  read strobe, high throughout FETCH.
- MemData  in  32  read data, valid on the last FETCH cycle.
- TxData  out  8  byte to transmit.
- TxValid  out  1  byte available.
- TxReady  in  1  transmitter accepts the byte; a transfer occurs when TxValid && TxReady at a posedge.

## Operation
- States: IDLE, FETCH, SEND, DONE. The state type is an enum.
- IDLE:
  - If Start=1 and WordCount≠0: latch BaseAddr&~3 and WordCount, then go to FETCH.
  - If Start=1 and WordCount=0: go directly to DONE. No memory access occurs.
- FETCH:
  - MemAddr holds the current address and MemRead=1.
  - Latency counter counts 0..MEM_LATENCY-1.
  - On the final count, latch MemData into a 32-bit shift register, clear the byte counter, and go to SEND.
- SEND:
  - TxValid=1 and TxData=shift[7:0].
  - On each transfer, shift right by 8 and increment the byte counter (2 bits).
  - On the 4th transfer, decrement the remaining count.
    - If the remaining count reaches 0, go to DONE.
    - Otherwise advance the address by 4 (mod 2^32, wraps 0xFFFFFFFC→0) and go to FETCH.
- DONE: Done=1 for exactly one cycle, then go to IDLE.
- Start received while Busy is ignored; the latched parameters do not change.
- TxData and TxValid stay stable while TxValid=1 and TxReady=0. TxValid never drops without a transfer, except on reset.
- TxReady is ignored outside SEND.

## Timing
- Reset values: Busy=0, Done=0, MemRead=0, MemAddr=0, TxValid=0, TxData=0, state=IDLE, all counters 0.
- Reset asserted mid-dump aborts the dump: TxValid and MemRead drop asynchronously, and no Done is issued.
- Start at edge N puts the block in FETCH at N+1, with MemAddr and MemRead valid from N+1.
- MemData is sampled at the edge ending the MEM_LATENCY-th FETCH cycle. The first TxValid is visible in the following cycle.
- Best case per word: MEM_LATENCY + 4 cycles (TxReady held high).
- TxValid is low during FETCH; there is no overlap between a fetch and sending.
- When the last byte is accepted at edge M: Done=1 in the cycle after M, and Busy=0 from the cycle after that.
- The WordCount=0 path: Start at N, Done in N+1, IDLE in N+2.

## Structure
- Add the following to the shared constants package / Constants.vh:
  - dump state enum type.
  - MEM_LATENCY default, shared with the load path.
  - byte-lane constant BYTES_PER_WORD=4.
- DATA_WIDTH comes from the existing shared macro.
- One sub-module, tx_byte_shifter. It holds:
  - the 32-bit load/shift register;
  - the 2-bit byte counter and last-byte flag;
  - the valid/ready transfer logic.
- The FSM, address, word and latency counters stay in mem_dump_serializer.

## Test plan
- Single word, zero wait:
  - Stimulus: memory[0x100]=0xDDCCBBAA, Start with BaseAddr=0x100, WordCount=1, TxReady=1.
  - Response: bytes AA, BB, CC, DD on consecutive cycles; one Done pulse; MemRead high for exactly 16 cycles.
- Backpressure:
  - Stimulus: same setup, TxReady toggling 1,0,0,1,…
  - Response: TxData holds each byte until accepted; no byte is lost or duplicated; exactly 4 transfers.
- Multi-word with wrap:
  - Stimulus: BaseAddr=0xFFFFFFFE, WordCount=2.
  - Response: reads at 0xFFFFFFFC then 0x00000000; 8 bytes; Done once.
- Zero count:
  - Stimulus: WordCount=0.
  - Response: no MemRead, no TxValid; Done one cycle after Start.
- Start while busy:
  - Stimulus: a second Start with different BaseAddr during SEND.
  - Response: ignored; the output stream matches the first command only.
- Reset mid-dump:
  - Stimulus: reset low during the second byte of word 1.
  - Response: TxValid and MemRead drop immediately; all outputs at reset values; a subsequent Start dumps correctly from its new BaseAddr.
